// File: rtl/mic_gate_pkg.sv
// Shared gate state encoding and default widths; also decoded by the MMIO
// core for STATUS, so the state encoding must stay stable.
package mic_gate_pkg;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_OPEN_CNT_W = 16;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    ATTACK = 2'd1,
    OPEN   = 2'd2,
    HOLD   = 2'd3
  } gate_state_t;

endpackage

// File: rtl/mic_win_timer.sv
// Detector window timer: 1-cycle win_start every WIN_CYCLES cycles while enabled.
// First pulse lands WIN_CYCLES cycles after enable is first sampled high.
module mic_win_timer #(
  parameter int WIN_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic win_start
);

  localparam int TW = $clog2(WIN_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(WIN_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          armed;

  // armed delays counting by one cycle so the first window is a full WIN_CYCLES long
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      armed     <= 1'b0;
      win_start <= 1'b0;
    end else if (!enable) begin
      timer     <= '0;
      armed     <= 1'b0;
      win_start <= 1'b0;
    end else begin
      armed     <= 1'b1;
      win_start <= 1'b0;
      if (armed) begin
        if (timer == LAST) begin
          timer     <= '0;
          win_start <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mic_gate_ctrl.sv
// Mic gate sequencer: window timing plus attack/hold debounce of threshold results.
// gate_open/gate_event follow the deciding level_ready_in by one cycle; enable low closes the gate.
module mic_gate_ctrl
  import mic_gate_pkg::*;
#(
  parameter int WIN_CYCLES = 100000,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int OPEN_CNT_W = DEF_OPEN_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      attack_cnt,
  input  logic [CNT_W-1:0]      hold_cnt,
  input  logic                  level_ready_in,
  input  logic                  above_thresh_in,
  output logic                  win_start,
  output logic                  gate_open,
  output logic                  gate_event,
  output logic [1:0]            state_out,
  output logic [OPEN_CNT_W-1:0] open_count
);

  gate_state_t      state, state_nxt;
  logic [CNT_W-1:0] run, run_nxt, run_inc;
  logic [CNT_W:0]   run_p1;
  logic             opening, gate_nxt;

  mic_win_timer #(.WIN_CYCLES(WIN_CYCLES)) u_win_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .win_start (win_start)
  );

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    run_p1    = {1'b0, run} + (CNT_W+1)'(1);
    run_inc   = (run == '1) ? run : run + CNT_W'(1);

    if (!enable) begin
      state_nxt = CLOSED;
      run_nxt   = '0;
    end else if (level_ready_in) begin
      case (state)
        CLOSED: begin
          if (above_thresh_in) begin
            if (attack_cnt <= CNT_W'(1)) begin
              state_nxt = OPEN;
              run_nxt   = '0;
            end else begin
              state_nxt = ATTACK;
              run_nxt   = CNT_W'(1);
            end
          end else begin
            run_nxt = '0;
          end
        end
        ATTACK: begin
          if (!above_thresh_in) begin
            state_nxt = CLOSED;
            run_nxt   = '0;
          end else if (run_p1 >= {1'b0, attack_cnt}) begin
            state_nxt = OPEN;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc;
          end
        end
        OPEN: begin
          if (!above_thresh_in) begin
            if (hold_cnt == '0) begin
              state_nxt = CLOSED;
              run_nxt   = '0;
            end else begin
              state_nxt = HOLD;
              run_nxt   = CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (above_thresh_in) begin
            state_nxt = OPEN;
            run_nxt   = '0;
          end else if (run >= hold_cnt) begin
            state_nxt = CLOSED;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc;
          end
        end
        default: begin
          state_nxt = CLOSED;
          run_nxt   = '0;
        end
      endcase
    end

    // HOLD->OPEN is a continuation of the same opening, not a new one
    opening  = ((state == CLOSED) || (state == ATTACK)) && (state_nxt == OPEN);
    gate_nxt = (state_nxt == OPEN) || (state_nxt == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLOSED;
      run        <= '0;
      gate_open  <= 1'b0;
      gate_event <= 1'b0;
      open_count <= '0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      gate_open  <= gate_nxt;
      gate_event <= gate_nxt != gate_open;
      if (opening && (open_count != '1))
        open_count <= open_count + OPEN_CNT_W'(1);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_mic_gate_ctrl.sv
// Bench for mic_gate_ctrl: window timing, attack/hold sequencing, saturation,
// enable override and async reset, checked against queued expectations.
module tb_mic_gate_ctrl;
  import mic_gate_pkg::*;

  localparam int WIN = 8;
  localparam int OCW = 4;

  typedef struct {
    logic [1:0]     st;
    logic           go;
    logic           ev;
    logic [OCW-1:0] cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [7:0]     attack_cnt = '0;
  logic [7:0]     hold_cnt = '0;
  logic           level_ready_in = 1'b0;
  logic           above_thresh_in = 1'b0;
  logic           win_start;
  logic           gate_open;
  logic           gate_event;
  logic [1:0]     state_out;
  logic [OCW-1:0] open_count;

  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_go = 1'b0;
  exp_t exp_q[$];
  logic ws_q[$];

  mic_gate_ctrl #(.WIN_CYCLES(WIN), .CNT_W(8), .OPEN_CNT_W(OCW)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .attack_cnt      (attack_cnt),
    .hold_cnt        (hold_cnt),
    .level_ready_in  (level_ready_in),
    .above_thresh_in (above_thresh_in),
    .win_start       (win_start),
    .gate_open       (gate_open),
    .gate_event      (gate_event),
    .state_out       (state_out),
    .open_count      (open_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock with the given inputs; expected result queued at drive, compared after the edge.
  task automatic step(input logic lr, input logic ab, input logic en,
                      input logic [1:0] st, input logic [OCW-1:0] cnt);
    exp_t e;
    @(negedge clk);
    level_ready_in  = lr;
    above_thresh_in = ab;
    enable          = en;
    e.st  = st;
    e.go  = (st == OPEN) || (st == HOLD);
    e.ev  = (e.go != prev_go);
    e.cnt = cnt;
    prev_go = e.go;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state_out", 32'(state_out), 32'(e.st));
    check("gate_open", 32'(gate_open), 32'(e.go));
    check("gate_event", 32'(gate_event), 32'(e.ev));
    check("open_count", 32'(open_count), 32'(e.cnt));
  endtask

  // Level pulse followed by an idle cycle in which the FSM must hold.
  task automatic pulse(input logic ab, input logic [1:0] st, input logic [OCW-1:0] cnt);
    step(1'b1, ab, 1'b1, st, cnt);
    step(1'b0, 1'b0, 1'b1, st, cnt);
  endtask

  // win_start over n cycles, cycle 0 being the edge that first samples enable high.
  task automatic win_check(input int n);
    for (int i = 0; i < n; i++)
      ws_q.push_back((i != 0) && (i % WIN == 0));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("win_start", 32'(win_start), 32'(ws_q.pop_front()));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_out), 32'(CLOSED));
    check("rst_gate", 32'(gate_open), 32'd0);
    check("rst_event", 32'(gate_event), 32'd0);
    check("rst_count", 32'(open_count), 32'd0);
    check("rst_win", 32'(win_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("win_idle", 32'(win_start), 32'd0);
    end
    @(negedge clk);
    enable = 1'b1;
    win_check(25);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("win_off", 32'(win_start), 32'd0);
    end

    attack_cnt = 8'd3;
    hold_cnt   = 8'd2;
    pulse(1'b1, ATTACK, 0);
    pulse(1'b1, ATTACK, 0);
    pulse(1'b1, OPEN, 1);
    pulse(1'b0, HOLD, 1);
    pulse(1'b0, HOLD, 1);
    pulse(1'b1, OPEN, 1);
    pulse(1'b0, HOLD, 1);
    pulse(1'b0, HOLD, 1);
    pulse(1'b0, CLOSED, 1);

    pulse(1'b1, ATTACK, 1);
    pulse(1'b1, ATTACK, 1);
    pulse(1'b0, CLOSED, 1);
    pulse(1'b1, ATTACK, 1);
    pulse(1'b0, CLOSED, 1);

    attack_cnt = 8'd0;
    hold_cnt   = 8'd0;
    pulse(1'b1, OPEN, 2);
    pulse(1'b0, CLOSED, 2);
    for (int k = 0; k < 14; k++) begin
      pulse(1'b1, OPEN, OCW'((3 + k > 15) ? 15 : 3 + k));
      pulse(1'b0, CLOSED, OCW'((3 + k > 15) ? 15 : 3 + k));
    end

    attack_cnt = 8'd3;
    pulse(1'b1, ATTACK, 15);
    attack_cnt = 8'd2;
    pulse(1'b1, OPEN, 15);

    step(1'b1, 1'b1, 1'b0, CLOSED, 15);
    step(1'b1, 1'b1, 1'b0, CLOSED, 15);
    attack_cnt = 8'd0;
    step(1'b1, 1'b1, 1'b1, OPEN, 15);
    step(1'b0, 1'b0, 1'b0, CLOSED, 15);

    step(1'b1, 1'b1, 1'b1, OPEN, 15);
    step(1'b0, 1'b0, 1'b1, OPEN, 15);
    step(1'b0, 1'b0, 1'b1, OPEN, 15);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state_out), 32'(CLOSED));
    check("arst_gate", 32'(gate_open), 32'd0);
    check("arst_event", 32'(gate_event), 32'd0);
    check("arst_count", 32'(open_count), 32'd0);
    check("arst_win", 32'(win_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_go = 1'b0;
    win_check(9);
    check("post_rst_state", 32'(state_out), 32'(CLOSED));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mic_gate_ctrl.md
Name: mic_gate_ctrl

Overview:
Gate sequencer between the microphone level detector and its MMIO core. It generates the detector's window timing and turns per-window threshold results into a debounced gate decision. The decision uses an attack/hold state machine, so single-window spikes do not open the gate and short dropouts do not close it. Its outputs drive downstream audio muting and a status/event path toward the MMIO layer.

Parameters:
WIN_CYCLES, 100000, detector window length in clk cycles (>=2)
CNT_W, 8, width of attack/hold counters and config inputs
OPEN_CNT_W, 16, width of the gate-open event counter

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  run/stop; low forces the idle state
attack_cnt  in  CNT_W  consecutive above-threshold windows required to open (0 or 1 = open on first)
hold_cnt  in  CNT_W  consecutive below-threshold windows tolerated while open before closing
level_ready_in  in  1  1-cycle pulse from detector at window end
above_thresh_in  in  1  detector comparator result, valid when level_ready_in=1
win_start  out  1  1-cycle pulse telling detector to clear peak and start a new window
gate_open  out  1  registered gate decision
gate_event  out  1  1-cycle pulse in the cycle gate_open changes value
state_out  out  2  current FSM state encoding
open_count  out  OPEN_CNT_W  number of CLOSED/ATTACK->OPEN transitions, saturating

Behaviour:
- Reset values: win_start=0, gate_open=0, gate_event=0, state_out=CLOSED (0), open_count=0, window timer=0, run counter=0.
- Window timer:
  - Counts 0..WIN_CYCLES-1 while enable=1.
  - In the cycle after the timer reaches WIN_CYCLES-1, the timer wraps to 0 and win_start=1 (registered).
  - The first win_start occurs exactly WIN_CYCLES cycles after enable is first sampled high.
- enable=0: timer held at 0, win_start=0, FSM forced to CLOSED, run counter=0, and level_ready_in is ignored.
  - If gate_open was 1, it drops next cycle with gate_event=1.
- FSM states: CLOSED=0, ATTACK=1, OPEN=2, HOLD=3. The FSM is evaluated only on cycles where level_ready_in=1 and enable=1; otherwise it holds. "above" means above_thresh_in=1.
  - CLOSED, above: if attack_cnt<=1, go OPEN; else go ATTACK with run=1.
  - CLOSED, below: stay, run=0.
  - ATTACK, above: if run+1>=attack_cnt, go OPEN with run=0; else run=run+1.
  - ATTACK, below: go CLOSED, run=0.
  - OPEN, above: stay.
  - OPEN, below: if hold_cnt==0, go CLOSED; else go HOLD with run=1.
  - HOLD, above: go OPEN, run=0.
  - HOLD, below: if run>=hold_cnt, go CLOSED with run=0; else run=run+1.
- gate_open=1 exactly when the registered state is OPEN or HOLD. It updates one cycle after the deciding level_ready_in.
- gate_event is asserted in the same cycle gate_open takes its new value.
- open_count increments on each entry to OPEN from CLOSED or ATTACK. It does not increment on HOLD->OPEN and saturates at all-ones.
- Run counter saturates at 2^CNT_W-1.
- attack_cnt and hold_cnt are read live at each evaluation. A change mid-sequence takes effect at the next level_ready_in; there is no retroactive transition.
- level_ready_in coincident with win_start: process both normally.
- level_ready_in coincident with enable falling: enable wins and the FSM goes CLOSED.
- Async rst mid-window: all state clears immediately and the window restarts after rst deasserts.

Decomposition:
- Package mic_gate_pkg holds the gate_state_t enum (CLOSED, ATTACK, OPEN, HOLD; 2-bit) and the default CNT_W/OPEN_CNT_W constants. This package is shared with the MMIO core for STATUS decoding.
- One natural sub-module, mic_win_timer: window counter plus win_start generation with enable clear.
- The FSM, run counter, and open_count stay in the top module.

Test Plan:
- WIN_CYCLES=8, enable rises at cycle 10 -> win_start pulses at cycles 18, 26, 34; none while enable=0.
- attack_cnt=3, hold_cnt=2, pulses with above=1,1,1 -> state CLOSED->ATTACK->ATTACK->OPEN; gate_open=1 and gate_event=1 one cycle after the 3rd pulse; open_count=1.
- From OPEN, hold_cnt=2, above=0,0,1 -> HOLD, HOLD, OPEN; gate_open stays 1 with no gate_event. Then above=0,0,0 -> CLOSED after the 3rd below window, gate_event=1.
- attack_cnt=3, above=1,1,0,1 -> ATTACK, ATTACK, CLOSED, ATTACK (run=1); gate never opens.
- attack_cnt=0, hold_cnt=0, above=1 then 0 -> opens on the 1st pulse and closes on the next; open_count=1. Force open_count to all-ones, then another opening -> open_count stays all-ones.
- Gate OPEN, drop enable (including the same cycle as a level_ready_in pulse) -> next cycle state=CLOSED, gate_open=0, gate_event=1. Assert rst mid-window -> all outputs zero immediately.
